sha256_stream_ctrl: RTL and testbench
=====================================

Name: sha256_stream_ctrl

Overview:
- Next-generation register front-end for the SHA-256 core.
- Accepts 512-bit message blocks through a decoded register bus into a staging buffer and commits them to a parametrised block FIFO.
- An FSM automatically sequences init/next pulses to the core, chains multi-block messages and latches the final digest.
- Sits between the axi_lite_interface decode and the existing sha256 core instance inside the tile peripheral wrapper.

Parameters:
- DATA_WIDTH, 64, register bus width (32 or 64); only bits [31:0] are significant.
- FIFO_DEPTH, 4, committed 512-bit blocks buffered (power of 2, at least 2).
- ADDR_WIDTH, 64, bus address width; decode uses addr_i[7:3].

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- reglk_i  in  8  register lock bits: [0] status read, [1] ctrl write, [2] data read, [3] data write, [4] digest read
- en_i  in  1  bus access strobe (already ANDed with access control)
- we_i  in  1  write enable
- addr_i  in  ADDR_WIDTH  byte address
- wdata_i  in  DATA_WIDTH  write data
- rdata_o  out  DATA_WIDTH  combinational read data
- core_init_o  out  1  one-cycle init pulse
- core_next_o  out  1  one-cycle next pulse
- core_block_o  out  512  block presented to the core
- core_ready_i  in  1  core idle
- core_digest_i  in  256  core digest
- core_valid_i  in  1  core digest valid

Behaviour:
Clock and reset:
- Single clock clk_i. rst_ni is asynchronous, active-low.
- Reset clears: staging, FIFO, digest, sticky bits and FSM (IDLE).
- All outputs reset to 0.

Register map (index = addr_i[7:3]):
- 0 CTRL (W). bit0 PUSH, bit1 FIRST, bit2 LAST, bit3 ABORT, bit4 CLR (clears DONE and OVF).
- 1 STATUS (R). bit0 core_ready, bit1 busy, bit2 fifo_full, bit3 fifo_empty, bit4 DONE, bit5 OVF, bits[8+:4] fifo_count.
- 2..17 DATA[0..15] (R/W, 32-bit). Staging block = {DATA[15],...,DATA[0]}.
- 18..25 DIGEST[0..7] (R). DIGEST[i] = digest[32i+31:32i].
- 26 IRQ_EN (R/W, bit0).
- Other indices: reads return 0; writes are ignored.
- Reads are zero-extended to DATA_WIDTH.
- A locked read returns 0. A locked write is ignored, with no side effects.

PUSH:
- Writes entry {FIRST, LAST, staging} to the FIFO and clears the staging buffer to 0 in the same cycle.
- If the FIFO is full: the entry is dropped, OVF is set sticky, and staging is still cleared.
- PUSH together with ABORT: ABORT wins and the push is discarded.

FSM states and transitions:
- IDLE: FIFO non-empty && core_ready_i -> ISSUE.
- ISSUE: pulses core_init_o if the head entry's FIRST is set, else core_next_o, for exactly 1 cycle. core_block_o holds the head block from ISSUE until the pop. -> WAIT_BUSY.
- WAIT_BUSY: ~core_ready_i -> WAIT_DONE.
- WAIT_DONE: core_ready_i && core_valid_i -> pop the head entry. If LAST: latch core_digest_i into DIGEST and set DONE. Then -> IDLE.
- Minimum latency from PUSH to ISSUE is 2 cycles.
- busy = (state != IDLE) || !fifo_empty.

Simultaneous events:
- PUSH and pop in the same cycle while full: the pop happens first, so the push is accepted.
- CLR and DONE set in the same cycle: the set wins.

ABORT:
- Flushes the FIFO and clears DIGEST and DONE immediately.
- If the FSM is in WAIT_BUSY or WAIT_DONE, it enters DRAIN. The core op cannot be cancelled, so the FSM waits for core_ready_i && core_valid_i, discards the result, then -> IDLE.

Reset mid-operation: clears everything immediately; no pulse is emitted afterwards.

Optional Feature:
- Macro SHA_STREAM_IRQ_EN.
- Defined: adds output irq_o (1 bit, registered) = DONE & IRQ_EN.bit0. irq_o resets to 0 and drops the cycle after CLR.
- Undefined: irq_o port is absent, IRQ_EN reads 0 and writes are ignored.

Decomposition:
- Package sha256_stream_pkg:
  - register index localparams
  - CTRL and STATUS bit positions
  - lock-bit indices
  - FSM state enum {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DRAIN}
  - packed struct blk_entry_t {first, last, block[511:0]}
- Sub-module sha_block_fifo: synchronous FIFO of blk_entry_t.
  - Parameter DEPTH.
  - Ports push, pop, flush, full, empty, count, head.
  - Pointer wrap via an extra MSB.

Test Plan:
- Single block "abc": DATA[15]=0x61626380, DATA[0]=0x18, others 0; PUSH|FIRST|LAST -> exactly one core_init_o pulse; DONE=1; DIGEST[7]=0xba7816bf, DIGEST[0]=0xf20015ad.
- Two-block 448-bit NIST message: PUSH FIRST, then PUSH LAST -> init then next pulses; DONE only after the second block; DIGEST[7]=0x248d6a61, DIGEST[0]=0x19db06c1.
- Overflow: hold core_ready_i=0 and push FIFO_DEPTH+1 blocks -> fifo_full=1, OVF=1, fifo_count=4; CLR -> OVF=0.
- Locks: reglk_i=0x1C -> DATA and DIGEST read 0, DATA writes ignored; reglk_i=0x02 -> PUSH ignored and fifo_count stays 0.
- ABORT in WAIT_DONE with 2 blocks queued -> FIFO empty immediately; no further pulses; DONE stays 0 after core_valid_i; FSM back in IDLE.
- Reset asserted in WAIT_DONE -> all outputs 0 at once; after release STATUS=0x9 (ready, empty) with core_ready_i=1.

Source files
------------

// File: rtl/sha256_stream_pkg.sv
// Shared types and constants for the SHA-256 streaming front-end.
// Register indices, CTRL/STATUS bit positions, lock bits, FSM states.
package sha256_stream_pkg;

    localparam logic [4:0] REG_CTRL    = 5'd0;
    localparam logic [4:0] REG_STATUS  = 5'd1;
    localparam logic [4:0] REG_DATA0   = 5'd2;
    localparam logic [4:0] REG_DATA15  = 5'd17;
    localparam logic [4:0] REG_DIGEST0 = 5'd18;
    localparam logic [4:0] REG_DIGEST7 = 5'd25;
    localparam logic [4:0] REG_IRQ_EN  = 5'd26;

    localparam int CTRL_PUSH  = 0;
    localparam int CTRL_FIRST = 1;
    localparam int CTRL_LAST  = 2;
    localparam int CTRL_ABORT = 3;
    localparam int CTRL_CLR   = 4;

    localparam int ST_READY = 0;
    localparam int ST_BUSY  = 1;
    localparam int ST_FULL  = 2;
    localparam int ST_EMPTY = 3;
    localparam int ST_DONE  = 4;
    localparam int ST_OVF   = 5;
    localparam int ST_COUNT = 8;

    localparam int LK_STATUS_RD = 0;
    localparam int LK_CTRL_WR   = 1;
    localparam int LK_DATA_RD   = 2;
    localparam int LK_DATA_WR   = 3;
    localparam int LK_DIGEST_RD = 4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        DRAIN
    } state_e;

    typedef struct packed {
        logic         first;
        logic         last;
        logic [511:0] block;
    } blk_entry_t;

endpackage

// File: rtl/sha256_stream_ctrl_if.sv
// Decoded register bus between the AXI-lite decode and the SHA front-end.
// master drives the access; slave returns combinational read data.
interface sha256_stream_ctrl_if
    import sha256_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
);
    logic [7:0]            reglk_i;
    logic                  en_i;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic [DATA_WIDTH-1:0] rdata_o;

    modport master (
        output reglk_i, en_i, we_i, addr_i, wdata_i,
        input  rdata_o
    );

    modport slave (
        input  reglk_i, en_i, we_i, addr_i, wdata_i,
        output rdata_o
    );
endinterface

// File: rtl/sha256_stream_ctrl_fifo.sv
// Synchronous FIFO of committed message blocks (sha_block_fifo).
// Pointers carry an extra MSB so full and empty are distinguishable.
module sha_block_fifo
    import sha256_stream_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push,
    input  blk_entry_t din,
    input  logic       pop,
    input  logic       flush,
    output logic       full,
    output logic       empty,
    output logic [AW:0] count,
    output blk_entry_t head
);
    blk_entry_t  mem_q [DEPTH];
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;

    // Pointer update: flush empties the queue, otherwise step on push/pop.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + (AW+1)'(1);
            if (pop)  rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Entry storage; contents are meaningless while the slot is unoccupied.
    always_ff @(posedge clk_i) begin
        if (push && !flush) mem_q[wptr_q[AW-1:0]] <= din;
    end

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count = wptr_q - rptr_q;
    assign head  = mem_q[rptr_q[AW-1:0]];
endmodule

// File: rtl/sha256_stream_ctrl.sv
// SHA-256 streaming register front-end: staging, block FIFO, core sequencer.
// Optional irq_o output enabled by defining SHA_STREAM_IRQ_EN.
module sha256_stream_ctrl
    import sha256_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    sha256_stream_ctrl_if.slave       bus,
    output logic                      core_init_o,
    output logic                      core_next_o,
    output logic [511:0]              core_block_o,
    input  logic                      core_ready_i,
    input  logic [255:0]              core_digest_i,
    input  logic                      core_valid_i
`ifdef SHA_STREAM_IRQ_EN
    ,
    output logic                      irq_o
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_WIDTH-1:0] addr;
    logic [4:0]  idx;
    logic [31:0] wd;
    logic [7:0]  lk;
    logic        wr;
    logic        ctrl_wr, data_wr;
    logic        abort, push_req, clr;
    logic [3:0]  data_sel;
    logic [2:0]  dig_sel;
    logic        is_status, is_data, is_digest;
    logic [31:0] status, rd_word;
    logic        unused_bits;

    state_e               state_q, state_d;
    logic [15:0][31:0]    staging_q, staging_d;
    logic [7:0][31:0]     digest_q, digest_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;

    logic        fifo_push, fifo_pop;
    logic        fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    blk_entry_t  fifo_din, fifo_head;
    logic        busy;

    assign addr = bus.addr_i;
    assign idx  = addr[7:3];
    assign wd   = bus.wdata_i[31:0];
    assign lk   = bus.reglk_i;
    assign wr   = bus.en_i & bus.we_i;

    assign unused_bits = ^{addr, bus.wdata_i, lk[7:5]};

    assign is_status = (idx == REG_STATUS);
    assign is_data   = (idx >= REG_DATA0) && (idx <= REG_DATA15);
    assign is_digest = (idx >= REG_DIGEST0) && (idx <= REG_DIGEST7);
    assign data_sel  = 4'(idx - REG_DATA0);
    assign dig_sel   = 3'(idx - REG_DIGEST0);

    assign ctrl_wr  = wr && (idx == REG_CTRL) && !lk[LK_CTRL_WR];
    assign data_wr  = wr && is_data && !lk[LK_DATA_WR];
    assign abort    = ctrl_wr && wd[CTRL_ABORT];
    assign push_req = ctrl_wr && wd[CTRL_PUSH] && !abort;
    assign clr      = ctrl_wr && wd[CTRL_CLR];

    // A pop in the same cycle frees the slot, so a push on full still lands.
    assign fifo_push = push_req && (!fifo_full || fifo_pop);
    assign fifo_din  = {wd[CTRL_FIRST], wd[CTRL_LAST], staging_q};

    sha_block_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (fifo_push),
        .din    (fifo_din),
        .pop    (fifo_pop),
        .flush  (abort),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count),
        .head   (fifo_head)
    );

    // Staging buffer: word writes, cleared by any push attempt.
    always_comb begin
        staging_d = staging_q;
        if (push_req)     staging_d = '0;
        else if (data_wr) staging_d[data_sel] = wd;
    end

    // Sequencer: issue head block, wait for the core, pop on completion.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && core_ready_i && !abort) state_d = ISSUE;
            end
            ISSUE: begin
                state_d = abort ? IDLE : WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (abort)              state_d = DRAIN;
                else if (!core_ready_i) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (abort) begin
                    state_d = DRAIN;
                end else if (core_ready_i && core_valid_i) begin
                    fifo_pop = 1'b1;
                    state_d  = IDLE;
                end
            end
            DRAIN: begin
                if (core_ready_i && core_valid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky flags and digest; a set in the same cycle beats CLR.
    always_comb begin
        done_d   = done_q;
        ovf_d    = ovf_q;
        digest_d = digest_q;
        if (clr) begin
            done_d = 1'b0;
            ovf_d  = 1'b0;
        end
        if (push_req && fifo_full && !fifo_pop) ovf_d = 1'b1;
        if (abort) begin
            done_d   = 1'b0;
            digest_d = '0;
        end
        if (fifo_pop && fifo_head.last) begin
            done_d   = 1'b1;
            digest_d = core_digest_i;
        end
    end

    // State, staging, flags and digest registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            staging_q <= '0;
            digest_q  <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            staging_q <= staging_d;
            digest_q  <= digest_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef SHA_STREAM_IRQ_EN
    logic is_irq_en;
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    assign is_irq_en = (idx == REG_IRQ_EN);

    // Interrupt enable register and registered level interrupt.
    always_comb begin
        irq_en_d = irq_en_q;
        if (wr && is_irq_en) irq_en_d = wd[0];
        irq_d = done_d & irq_en_d;
    end

    // Interrupt registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_o = irq_q;
`endif

    assign busy = (state_q != IDLE) || !fifo_empty;

    // Status word assembly.
    always_comb begin
        status              = '0;
        status[ST_READY]    = core_ready_i;
        status[ST_BUSY]     = busy;
        status[ST_FULL]     = fifo_full;
        status[ST_EMPTY]    = fifo_empty;
        status[ST_DONE]     = done_q;
        status[ST_OVF]      = ovf_q;
        status[ST_COUNT+:4] = 4'(fifo_count);
    end

    // Read decode; locked or unmapped reads return zero.
    always_comb begin
        rd_word = '0;
        unique case (1'b1)
            is_status: if (!lk[LK_STATUS_RD]) rd_word = status;
            is_data:   if (!lk[LK_DATA_RD])   rd_word = staging_q[data_sel];
            is_digest: if (!lk[LK_DIGEST_RD]) rd_word = digest_q[dig_sel];
`ifdef SHA_STREAM_IRQ_EN
            is_irq_en: rd_word = {31'b0, irq_en_q};
`endif
            default:   rd_word = '0;
        endcase
    end

    assign bus.rdata_o = DATA_WIDTH'(rd_word);

    assign core_init_o  = (state_q == ISSUE) && fifo_head.first;
    assign core_next_o  = (state_q == ISSUE) && !fifo_head.first;
    assign core_block_o = (state_q == ISSUE || state_q == WAIT_BUSY ||
                           state_q == WAIT_DONE) ? fifo_head.block : '0;
endmodule

// File: tb/tb_sha256_stream_ctrl.sv
// Directed bench for sha256_stream_ctrl with a simple behavioural core.
// Covers single/multi-block, overflow, locks, abort and mid-op reset.
module tb_sha256_stream_ctrl;
    import sha256_stream_pkg::*;

    localparam logic [255:0] DIG_ABC =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_NIST =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [255:0] DIG_MID = {8{32'h5a5a0001}};
    localparam int CORE_LAT = 6;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    sha256_stream_ctrl_if #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) bus_if();

    logic         core_init_o, core_next_o;
    logic [511:0] core_block_o;
    logic         core_ready_i, core_valid_i;
    logic [255:0] core_digest_i;
`ifdef SHA_STREAM_IRQ_EN
    logic         irq;
`endif

    sha256_stream_ctrl #(
        .DATA_WIDTH (64),
        .FIFO_DEPTH (4),
        .ADDR_WIDTH (64)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .bus           (bus_if),
        .core_init_o   (core_init_o),
        .core_next_o   (core_next_o),
        .core_block_o  (core_block_o),
        .core_ready_i  (core_ready_i),
        .core_digest_i (core_digest_i),
        .core_valid_i  (core_valid_i)
`ifdef SHA_STREAM_IRQ_EN
        ,
        .irq_o         (irq)
`endif
    );

    logic         core_stall;
    logic [255:0] res_init, res_next;
    logic         core_busy;
    int           core_cnt;
    logic [255:0] core_pend;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            core_busy     <= 1'b0;
            core_cnt      <= 0;
            core_valid_i  <= 1'b0;
            core_digest_i <= '0;
            core_pend     <= '0;
        end else if (core_busy) begin
            if (core_cnt == 0) begin
                core_busy     <= 1'b0;
                core_valid_i  <= 1'b1;
                core_digest_i <= core_pend;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end else if (core_init_o || core_next_o) begin
            core_busy    <= 1'b1;
            core_cnt     <= CORE_LAT;
            core_valid_i <= 1'b0;
            core_pend    <= core_init_o ? res_init : res_next;
        end
    end

    assign core_ready_i = !core_busy && !core_stall;

    int n_init = 0;
    int n_next = 0;
    always @(negedge clk_i) begin
        if (core_init_o) n_init++;
        if (core_next_o) n_next++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] d);
        bus_if.en_i    = 1'b1;
        bus_if.we_i    = 1'b1;
        bus_if.addr_i  = {56'b0, idx, 3'b0};
        bus_if.wdata_i = {32'b0, d};
        @(posedge clk_i);
        #1;
        bus_if.en_i = 1'b0;
        bus_if.we_i = 1'b0;
    endtask

    task automatic rd(input logic [4:0] idx, output logic [31:0] d);
        bus_if.en_i   = 1'b1;
        bus_if.we_i   = 1'b0;
        bus_if.addr_i = {56'b0, idx, 3'b0};
        #1;
        d = bus_if.rdata_o[31:0];
        bus_if.en_i = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [4:0] idx,
                             input logic [31:0] exp);
        logic [31:0] d;
        rd(idx, d);
        check(tag, d, exp);
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] s;
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            rd(REG_STATUS, s);
            if (s[ST_DONE]) hit = 1'b1;
            else tick(1);
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    task automatic wait_pulse(input string tag, input bit want_next);
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (want_next ? core_next_o : core_init_o) hit = 1'b1;
            else tick(1);
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    int i0, x0;

    initial begin
        bus_if.reglk_i = 8'h00;
        bus_if.en_i    = 1'b0;
        bus_if.we_i    = 1'b0;
        bus_if.addr_i  = '0;
        bus_if.wdata_i = '0;
        core_stall     = 1'b0;
        res_init       = DIG_ABC;
        res_next       = '0;

        tick(3);
        check("rst_init", 32'(core_init_o), 32'd0);
        check("rst_next", 32'(core_next_o), 32'd0);
        check("rst_block", 32'(|core_block_o), 32'd0);
        rst_ni = 1'b1;
        tick(1);
        check_reg("rst_status", REG_STATUS, 32'h9);

        wr(REG_DATA15, 32'h61626380);
        wr(REG_DATA0, 32'h00000018);
        check_reg("data15_rb", REG_DATA15, 32'h61626380);
        i0 = n_init;
        x0 = n_next;
        wr(REG_CTRL, 32'h7);
        check_reg("abc_pushed", REG_STATUS, 32'h103);
        check_reg("staging_clr", REG_DATA15, 32'h0);
        tick(1);
        check("abc_init", 32'(core_init_o), 32'd1);
        check("abc_blk_hi", core_block_o[511:480], 32'h61626380);
        check("abc_blk_lo", core_block_o[31:0], 32'h18);
        wait_done("abc_done");
        check_reg("abc_status", REG_STATUS, 32'h19);
        check("abc_ninit", 32'(n_init - i0), 32'd1);
        check("abc_nnext", 32'(n_next - x0), 32'd0);
        check_reg("abc_dig7", REG_DIGEST7, 32'hba7816bf);
        check_reg("abc_dig0", REG_DIGEST0, 32'hf20015ad);
        wr(REG_CTRL, 32'h10);
        check_reg("clr_status", REG_STATUS, 32'h9);

        res_init = DIG_MID;
        res_next = DIG_NIST;
        i0 = n_init;
        x0 = n_next;
        wr(REG_DATA0, 32'h1);
        wr(REG_CTRL, 32'h3);
        wr(REG_DATA0, 32'h2);
        wr(REG_CTRL, 32'h5);
        wait_pulse("two_next_seen", 1'b1);
        check("two_blk2", core_block_o[31:0], 32'h2);
        check_reg("two_mid_status", REG_STATUS, 32'h103);
        check_reg("two_mid_dig0", REG_DIGEST0, 32'hf20015ad);
        wait_done("two_done");
        check_reg("two_dig7", REG_DIGEST7, 32'h248d6a61);
        check_reg("two_dig0", REG_DIGEST0, 32'h19db06c1);
        check("two_ninit", 32'(n_init - i0), 32'd1);
        check("two_nnext", 32'(n_next - x0), 32'd1);
        wr(REG_CTRL, 32'h10);

        core_stall = 1'b1;
        repeat (4) wr(REG_CTRL, 32'h7);
        check_reg("ovf_full", REG_STATUS, 32'h406);
        wr(REG_CTRL, 32'h7);
        check_reg("ovf_set", REG_STATUS, 32'h426);
        wr(REG_CTRL, 32'h10);
        check_reg("ovf_clr", REG_STATUS, 32'h406);
        wr(REG_CTRL, 32'h8);
        check_reg("ovf_flush", REG_STATUS, 32'h8);
        core_stall = 1'b0;
        check_reg("ovf_idle", REG_STATUS, 32'h9);

        wr(REG_DATA0, 32'h12345678);
        bus_if.reglk_i = 8'h1C;
        check_reg("lk_data_rd", REG_DATA0, 32'h0);
        check_reg("lk_dig_rd", REG_DIGEST7, 32'h0);
        wr(REG_DATA0, 32'hdeadbeef);
        bus_if.reglk_i = 8'h00;
        check_reg("lk_data_wr", REG_DATA0, 32'h12345678);
        bus_if.reglk_i = 8'h02;
        i0 = n_init;
        wr(REG_CTRL, 32'h7);
        check_reg("lk_push", REG_STATUS, 32'h9);
        tick(5);
        check("lk_no_pulse", 32'(n_init - i0), 32'd0);
        bus_if.reglk_i = 8'h00;

        res_init = DIG_ABC;
        res_next = DIG_NIST;
        wr(REG_CTRL, 32'h3);
        wr(REG_CTRL, 32'h5);
        wait_pulse("ab_init_seen", 1'b0);
        tick(2);
        check_reg("ab_pre", REG_STATUS, 32'h202);
        i0 = n_init;
        x0 = n_next;
        wr(REG_CTRL, 32'h8);
        check_reg("ab_flushed", REG_STATUS, 32'hA);
        check_reg("ab_dig_clr", REG_DIGEST7, 32'h0);
        check("ab_block", 32'(|core_block_o), 32'd0);
        tick(20);
        check_reg("ab_idle", REG_STATUS, 32'h9);
        check("ab_ninit", 32'(n_init - i0), 32'd0);
        check("ab_nnext", 32'(n_next - x0), 32'd0);

        wr(REG_DATA0, 32'h5);
        wr(REG_CTRL, 32'h7);
        wait_pulse("rs_init_seen", 1'b0);
        tick(2);
        wr(5'd3, 32'h77);
        check("rs_blk", core_block_o[31:0], 32'h5);
        rst_ni = 1'b0;
        #1;
        check("rs_init", 32'(core_init_o), 32'd0);
        check("rs_next", 32'(core_next_o), 32'd0);
        check("rs_block", 32'(|core_block_o), 32'd0);
        tick(2);
        rst_ni = 1'b1;
        tick(1);
        check_reg("rs_status", REG_STATUS, 32'h9);
        check_reg("rs_staging", 5'd3, 32'h0);
        i0 = n_init;
        x0 = n_next;
        tick(15);
        check("rs_ninit", 32'(n_init - i0), 32'd0);
        check("rs_nnext", 32'(n_next - x0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
